// File: rtl/res_reader.sv
// rtl/res_reader.sv - result buffer drain controller; define RES_READER_RELU_EN to clamp negative entries to zero
module res_reader #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BIT_DEPTH-1:0]  rd_data,
  output logic [BIT_DEPTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDR_WIDTH-1:0] remaining, remaining_nxt;
  logic                  err_q, err_nxt;

  // Two-entry output FIFO: storage, read/write slot indices and occupancy
  logic [BIT_DEPTH-1:0]  fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_idx, rd_idx;
  logic [1:0]            occ;

  logic                  push, pop;
  logic                  base_ok;
  logic [BIT_DEPTH-1:0]  push_data;

  // base_addr is compared one bit wider so DEPTH = 2^ADDR_WIDTH still works
  assign base_ok = ({1'b0, base_addr} < DEPTH_EXT);

  // Value written into the FIFO for the current read
`ifdef RES_READER_RELU_EN
  assign push_data = rd_data[BIT_DEPTH-1] ? '0 : rd_data;
`else
  assign push_data = rd_data;
`endif

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_data[rd_idx];
  assign out_last  = fifo_last[rd_idx] & out_valid;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign rd_en     = push;
  assign rd_addr   = ptr;

  // Next-state, pointer/remaining updates and the read strobe
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    err_nxt       = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!base_ok) begin
            err_nxt = 1'b1;
          end else if (count == '0) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt       = base_addr;
            remaining_nxt = count;
            state_nxt     = READ;
          end
        end
      end
      READ: begin
        // A full FIFO can still take a read when the head leaves this cycle
        if (occ != 2'd2 || pop) begin
          push          = 1'b1;
          ptr_nxt       = (ptr == LAST_ADDR) ? '0 : ptr + ONE;
          remaining_nxt = remaining - ONE;
          if (remaining == ONE) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers: state, address pointer, beats left, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
      err_q     <= err_nxt;
    end
  end

  // Output FIFO: write on push, advance head on pop, track occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_idx       <= 1'b0;
      rd_idx       <= 1'b0;
      occ          <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_idx] <= push_data;
        fifo_last[wr_idx] <= (remaining == ONE);
        wr_idx            <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_res_reader.sv
// tb/tb_res_reader.sv - scoreboard bench for res_reader
module tb_res_reader;
  localparam int BW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          busy, rd_en, out_valid, out_last, done, err;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_data, out_data;
  logic          out_ready = 1'b0;

  logic [BW-1:0] mem [0:DEPTH-1];
  logic [BW:0]   sb_q [$];
  int            vectors = 0;
  int            miscompares = 0;

  res_reader #(.BIT_DEPTH(BW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rd_data = (rd_addr < AW'(DEPTH)) ? mem[rd_addr[4:0]] : '0;

  function automatic logic [BW-1:0] model_px(logic [BW-1:0] v);
`ifdef RES_READER_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_load(int b, int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({(i == n - 1), model_px(mem[(b + i) % DEPTH])});
    end
  endtask

  task automatic issue(int b, int n);
    start = 1'b1;
    base_addr = AW'(b);
    count = AW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, rd_en, out_valid, out_last, done, err} !== 6'b0 || rd_addr !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state got ctl=%b rd_addr=%0d out_data=%0d expected all zero",
               {busy, rd_en, out_valid, out_last, done, err}, rd_addr, out_data);
    end
  endtask

  task automatic test_basic();
    int beats;
    int done_cyc;
    logic [BW:0] exp;
    beats = 0;
    done_cyc = -1;
    out_ready = 1'b1;
    sb_load(3, 4);
    issue(3, 4);
    vectors++;
    if (rd_en !== 1'b1 || rd_addr !== AW'(3)) begin
      miscompares++;
      $display("FAIL basic_first_read got rd_en=%b rd_addr=%0d expected 1/3", rd_en, rd_addr);
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL basic_extra_beat got data=%0d expected no beat", out_data);
        end else begin
          exp = sb_q.pop_front();
          if ({out_last, out_data} !== exp || cyc != beats + 2) begin
            miscompares++;
            $display("FAIL basic_beat got last=%b data=%0d cycle=%0d expected last=%b data=%0d cycle=%0d",
                     out_last, out_data, cyc, exp[BW], exp[BW-1:0], beats + 2);
          end
        end
        beats++;
      end
      if (done) done_cyc = cyc;
      if (cyc == 7) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_busy_fall got busy=%b in cycle 7 expected 0", busy);
        end
      end
      tick();
    end
    vectors++;
    if (done_cyc != 6 || beats != 4) begin
      miscompares++;
      $display("FAIL basic_done got done_cycle=%0d beats=%0d expected 6/4", done_cyc, beats);
    end
  endtask

  task automatic test_wrap();
    int beats;
    bit done_seen;
    logic [BW:0] exp;
    beats = 0;
    done_seen = 0;
    out_ready = 1'b1;
    sb_load(24, 4);
    issue(24, 4);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (out_valid && out_ready) begin
        vectors++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        if ({out_last, out_data} !== exp) begin
          miscompares++;
          $display("FAIL wrap_beat got last=%b data=%0d expected last=%b data=%0d",
                   out_last, out_data, exp[BW], exp[BW-1:0]);
        end
        beats++;
      end
      if (done) done_seen = 1;
      tick();
    end
    vectors++;
    if (beats != 4 || !done_seen || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_total got beats=%0d done=%0d left=%0d expected 4/1/0", beats, done_seen, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int beats;
    int occ_m;
    bit done_seen;
    bit stalled;
    bit pop;
    logic [BW-1:0] held;
    logic [BW:0] exp;
    beats = 0;
    occ_m = 0;
    done_seen = 0;
    stalled = 0;
    held = '0;
    sb_load(0, 5);
    issue(0, 5);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      out_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      #1;
      pop = out_valid && out_ready;
      vectors++;
      if (out_valid !== (occ_m != 0) || (rd_en && occ_m == 2 && !pop)) begin
        miscompares++;
        $display("FAIL bp_fifo_level got valid=%b rd_en=%b expected valid=%b occupancy=%0d pop=%b",
                 out_valid, rd_en, (occ_m != 0), occ_m, pop);
      end
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          miscompares++;
          $display("FAIL bp_stable got valid=%b data=%0d expected 1/%0d", out_valid, out_data, held);
        end
      end
      if (pop) begin
        vectors++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        if ({out_last, out_data} !== exp) begin
          miscompares++;
          $display("FAIL bp_beat got last=%b data=%0d expected last=%b data=%0d",
                   out_last, out_data, exp[BW], exp[BW-1:0]);
        end
        beats++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      occ_m = occ_m + (rd_en ? 1 : 0) - (pop ? 1 : 0);
      if (done) begin
        done_seen = 1;
        break;
      end
      tick();
    end
    tick();
    out_ready = 1'b1;
    vectors++;
    if (!done_seen || beats != 5 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_total got done=%0d beats=%0d left=%0d expected 1/5/0", done_seen, beats, sb_q.size());
    end
  endtask

  task automatic test_edge();
    int beats;
    bit err_seen;
    logic [BW:0] exp;
    out_ready = 1'b1;
    issue(7, 0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL count0_cycle1 got done=%b busy=%b valid=%b expected 1/1/0", done, busy, out_valid);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL count0_cycle2 got done=%b busy=%b valid=%b expected 0/0/0", done, busy, out_valid);
    end
    issue(26, 3);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_base_cycle1 got err=%b busy=%b expected 1/0", err, busy);
    end
    tick();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_base_cycle2 got err=%b busy=%b valid=%b expected 0/0/0", err, busy, out_valid);
    end
    beats = 0;
    err_seen = 0;
    sb_load(0, 3);
    issue(0, 3);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin
        start = 1'b1;
        base_addr = AW'(5);
        count = AW'(2);
      end
      if (cyc == 3) start = 1'b0;
      #1;
      if (err) err_seen = 1;
      if (out_valid && out_ready) begin
        vectors++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        if ({out_last, out_data} !== exp) begin
          miscompares++;
          $display("FAIL busy_start_beat got last=%b data=%0d expected last=%b data=%0d",
                   out_last, out_data, exp[BW], exp[BW-1:0]);
        end
        beats++;
      end
      tick();
    end
    vectors++;
    if (beats != 3 || err_seen || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_ignored got beats=%0d err=%0d busy=%b expected 3/0/0", beats, err_seen, busy);
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    int done_cnt;
    logic [BW:0] exp;
    out_ready = 1'b1;
    sb_q.delete();
    issue(0, 6);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'd1) begin
      miscompares++;
      $display("FAIL mid_beat1 got valid=%b data=%0d expected 1/1", out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'd2) begin
      miscompares++;
      $display("FAIL mid_beat2 got valid=%b data=%0d expected 1/2", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, rd_en, out_valid, out_last, done, err} !== 6'b0 || rd_addr !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got ctl=%b rd_addr=%0d out_data=%0d expected all zero",
               {busy, rd_en, out_valid, out_last, done, err}, rd_addr, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beats = 0;
    done_cnt = 0;
    sb_load(2, 2);
    issue(2, 2);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (out_valid && out_ready) begin
        vectors++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        if ({out_last, out_data} !== exp) begin
          miscompares++;
          $display("FAIL replay_beat got last=%b data=%0d expected last=%b data=%0d",
                   out_last, out_data, exp[BW], exp[BW-1:0]);
        end
        beats++;
      end
      if (done) done_cnt++;
      tick();
    end
    vectors++;
    if (beats != 2 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL replay_total got beats=%0d done_pulses=%0d expected 2/1", beats, done_cnt);
    end
  endtask

`ifdef RES_READER_RELU_EN
  task automatic test_relu();
    int beats;
    logic [BW:0] exp;
    mem[0] = 8'h85;
    mem[1] = 8'h7F;
    mem[2] = 8'hFF;
    out_ready = 1'b1;
    beats = 0;
    sb_q.push_back({1'b0, 8'h00});
    sb_q.push_back({1'b0, 8'h7F});
    sb_q.push_back({1'b1, 8'h00});
    issue(0, 3);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (out_valid && out_ready) begin
        vectors++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        if ({out_last, out_data} !== exp) begin
          miscompares++;
          $display("FAIL relu_beat got last=%b data=%0h expected last=%b data=%0h",
                   out_last, out_data, exp[BW], exp[BW-1:0]);
        end
        beats++;
      end
      tick();
    end
    vectors++;
    if (beats != 3) begin
      miscompares++;
      $display("FAIL relu_total got beats=%0d expected 3", beats);
    end
    for (int i = 0; i < 3; i++) mem[i] = BW'(i + 1);
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = BW'(i + 1);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge();
    test_reset_mid();
`ifdef RES_READER_RELU_EN
    test_relu();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/res_reader.md
# res_reader

Drain controller for the result buffer: on a start command it reads a contiguous run of `count` entries, beginning at `base_addr`, through the buffer's combinational read port. It then streams them out on a valid/ready interface, wrapping the address at `DEPTH`. It is the read-side counterpart of the result buffer writer and feeds the NPU output/DMA path. A 2-entry output FIFO absorbs backpressure without losing throughput.

## Interface
- `BIT_DEPTH`, 8, data width of a buffer entry
- `ADDR_WIDTH`, 10, buffer address width
- `DEPTH`, 26, number of buffer entries (≤ 2^ADDR_WIDTH)

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  command pulse; sampled only when `busy`=0
- `base_addr`  in  ADDR_WIDTH  first entry to read; latched on accepted start
- `count`  in  ADDR_WIDTH  entries to read; latched on accepted start
- `busy`  out  1  command in progress
- `rd_en`  out  1  read strobe to buffer
- `rd_addr`  out  ADDR_WIDTH  buffer read address; `rd_data` is valid in the same cycle
- `rd_data`  in  BIT_DEPTH  buffer read data
- `out_data`  out  BIT_DEPTH  stream data
- `out_valid`  out  1  stream data valid
- `out_ready`  in  1  downstream accept
- `out_last`  out  1  marks final beat of the command
- `done`  out  1  one-cycle pulse when the command completes
- `err`  out  1  one-cycle pulse when a start is rejected

## Operation
- Reset values: `busy`, `rd_en`, `out_valid`, `out_last`, `done`, `err` are 0; `rd_addr` and `out_data` are 0; FIFO is empty; state is IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE:**
  - `start`=1 with `base_addr` ≥ DEPTH → `err` pulses the next cycle; stay in IDLE.
  - `start`=1 with `count`=0 → go to DONE; no beats are produced.
  - Otherwise, latch the address pointer (= `base_addr`) and `remaining` (= `count`), then go to READ.
- **READ:**
  - Push condition: FIFO occupancy < 2, or occupancy = 2 with a pop in the same cycle.
  - When the push condition holds, `rd_en`=1 and `rd_data` is written into the FIFO with tag last = (`remaining`=1).
  - Each push moves the pointer to pointer+1, wrapping from DEPTH-1 to 0, and decrements `remaining`.
  - On the push with `remaining`=1, go to DRAIN.
  - `rd_addr` always shows the pointer; `rd_en`=0 when no push occurs.
- **DRAIN:** wait until the FIFO is empty (including a pop in the current cycle), then go to DONE.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- `busy`=1 in READ, DRAIN and DONE.
- Stream rules:
  - `out_valid` = FIFO not empty.
  - `out_data` and `out_last` come from the FIFO head.
  - A pop occurs when `out_valid` and `out_ready` are both 1.
  - Data must stay stable while `out_valid`=1 and `out_ready`=0.
- `start` while `busy`=1 is ignored; no error is flagged.
- Simultaneous push and pop at occupancy 1 or 2 leaves occupancy unchanged.
- Async reset mid-command aborts immediately: the FIFO is flushed and no `done` is generated.

## Timing
- Accepted start at edge 0 → READ from cycle 1, first `rd_en` in cycle 1.
- First `out_valid` in cycle 2, because FIFO output is registered.
- With `out_ready` held at 1 and N ≥ 1 entries:
  - Beats occur in cycles 2..N+1, with `out_last` in cycle N+1.
  - `done` pulses in cycle N+2.
  - `busy` falls in cycle N+3.
  - Throughput is 1 beat per cycle.
- `count`=0: `done` pulses in cycle 1 and `busy` is 1 for that cycle only.
- Rejected start at edge 0 → `err` pulses in cycle 1; `busy` stays 0.
- With `out_ready`=0: at most 2 reads are issued before `rd_en` stalls. Reads resume in the same cycle that a pop occurs.

## Configuration
- `RES_READER_RELU_EN` defined: each entry is treated as a signed BIT_DEPTH value. If its MSB is 1, the value pushed into the FIFO is 0; otherwise it is pushed unchanged. Timing is identical in both configurations.
- Not defined: `rd_data` is passed through unmodified.

## Test plan
- Buffer holds i+1 at address i. Send start with base=3, count=4, `out_ready`=1 → beats 4,5,6,7 in cycles 2–5; `out_last` on 7; `done` in cycle 6.
- Wrap-around: base=24, count=4 → beats read addresses 24, 25, 0, 1, i.e. values 25, 26, 1, 2.
- Backpressure: base=0, count=5, with `out_ready` toggled 1,0,0,1,… → every value 1..5 delivered exactly once, in order; `rd_en` never high while FIFO is full without a pop; `out_data` stable while stalled.
- Edge commands:
  - count=0 → `done` in cycle 1 and no `out_valid`.
  - base=26 → `err` pulse and `busy` stays 0.
  - start while busy → ignored.
- Reset mid-command: deassert `rst_n` during beat 2 of a count=6 run → all outputs 0 immediately. A new start after reset replays cleanly.
- With `RES_READER_RELU_EN`: entries 0x85, 0x7F, 0xFF → beats 0x00, 0x7F, 0x00.
